// File: rtl/conv_encoder_punct.sv
// Frame-based convolutional encoder with per-frame puncturing (1/2, 2/3, 3/4)
// and automatic zero-tail termination; serial coded-bit output with valid/ready.
module conv_encoder_punct #(
    parameter int unsigned K  = 7,
    parameter logic [K-1:0] G0 = 7'o171,
    parameter logic [K-1:0] G1 = 7'o133
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rate_sel_i,
    input  logic       in_bit_i,
    input  logic       in_valid_i,
    input  logic       in_last_i,
    output logic       in_ready_o,
    output logic       out_bit_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       busy_o
);

    localparam int unsigned SW = K - 1;
    localparam int unsigned TW = $clog2(K);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    state_t          state_q, state_n;
    logic [SW-1:0]   s_q, s_n;
    logic [1:0]      p_q, p_n;
    logic [1:0]      rate_q, rate_n;
    logic [TW-1:0]   tail_q, tail_n;
    logic            out_bit_q, out_bit_n;
    logic            out_valid_q, out_valid_n;
    logic            out_last_q, out_last_n;
    logic            sec_bit_q, sec_bit_n;
    logic            sec_valid_q, sec_valid_n;
    logic            sec_last_q, sec_last_n;
    logic            busy_q, busy_n;

    logic            out_fire;
    logic            slot_free;
    logic            in_ready_c;
    logic            accept;
    logic            tail_load;
    logic            load;
    logic            final_load;
    logic            enc_in;
    logic [K-1:0]    w;
    logic            bit_a;
    logic            bit_b;
    logic [1:0]      eff_rate;
    logic            emit_a;
    logic            emit_b;
    logic            p_wrap;

    // The holding register is free for a new load once it is empty, or its
    // single remaining bit leaves this cycle.
    assign out_fire   = out_valid_q && out_ready_i;
    assign slot_free  = !out_valid_q || (!sec_valid_q && out_ready_i);
    assign in_ready_c = !rst && (state_q != TAIL) && slot_free;
    assign accept     = in_valid_i && in_ready_c;
    assign tail_load  = (state_q == TAIL) && (tail_q != '0) && slot_free;
    assign load       = accept || tail_load;
    assign final_load = tail_load && (tail_q == TW'(1));

    assign enc_in = accept ? in_bit_i : 1'b0;
    assign w      = {enc_in, s_q};
    assign bit_a  = ^(w & G0);
    assign bit_b  = ^(w & G1);

    // Rate is taken live from the port only for the frame's first bit.
    assign eff_rate = (state_q == IDLE) ? ((rate_sel_i == 2'd3) ? 2'd0 : rate_sel_i)
                                        : rate_q;
    assign emit_a = (p_q != 2'd2);
    assign emit_b = (eff_rate == 2'd0) || (p_q == 2'd0) || (p_q == 2'd2);
    assign p_wrap = (eff_rate == 2'd0) || ((eff_rate == 2'd1) && (p_q == 2'd1)) ||
                    (p_q == 2'd2);

    always_comb begin
        state_n     = state_q;
        s_n         = s_q;
        p_n         = p_q;
        rate_n      = rate_q;
        tail_n      = tail_q;
        out_bit_n   = out_bit_q;
        out_valid_n = out_valid_q;
        out_last_n  = out_last_q;
        sec_bit_n   = sec_bit_q;
        sec_valid_n = sec_valid_q;
        sec_last_n  = sec_last_q;
        busy_n      = busy_q;

        if (out_fire) begin
            if (sec_valid_q) begin
                out_bit_n   = sec_bit_q;
                out_last_n  = sec_last_q;
                sec_valid_n = 1'b0;
                sec_last_n  = 1'b0;
            end else begin
                out_valid_n = 1'b0;
                out_last_n  = 1'b0;
            end
        end

        if (load) begin
            s_n         = {enc_in, s_q[SW-1:1]};
            p_n         = p_wrap ? 2'd0 : p_q + 2'd1;
            out_valid_n = 1'b1;
            if (emit_a && emit_b) begin
                out_bit_n   = bit_a;
                out_last_n  = 1'b0;
                sec_bit_n   = bit_b;
                sec_valid_n = 1'b1;
                sec_last_n  = final_load;
            end else begin
                out_bit_n   = emit_a ? bit_a : bit_b;
                out_last_n  = final_load;
                sec_valid_n = 1'b0;
                sec_last_n  = 1'b0;
            end
            if (tail_load) begin
                tail_n = tail_q - TW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rate_n = eff_rate;
                    busy_n = 1'b1;
                    if (in_last_i) begin
                        state_n = TAIL;
                        tail_n  = TW'(SW);
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && in_last_i) begin
                    state_n = TAIL;
                    tail_n  = TW'(SW);
                end
            end
            TAIL: begin
                if (out_fire && out_last_q) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    s_n     = '0;
                    p_n     = 2'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            p_q         <= 2'd0;
            rate_q      <= 2'd0;
            tail_q      <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sec_bit_q   <= 1'b0;
            sec_valid_q <= 1'b0;
            sec_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            s_q         <= s_n;
            p_q         <= p_n;
            rate_q      <= rate_n;
            tail_q      <= tail_n;
            out_bit_q   <= out_bit_n;
            out_valid_q <= out_valid_n;
            out_last_q  <= out_last_n;
            sec_bit_q   <= sec_bit_n;
            sec_valid_q <= sec_valid_n;
            sec_last_q  <= sec_last_n;
            busy_q      <= busy_n;
        end
    end

    assign in_ready_o  = in_ready_c;
    assign out_bit_o   = out_bit_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: directed K=3 frames from hand-derived streams,
// then random K=7 frames against a behavioural encoder/puncture model.
module tb_conv_encoder_punct;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [1:0] rate_sel;
    logic       in_bit, in_valid, in_last, out_ready;

    logic r3, b3, v3, l3, y3;
    logic r7, b7, v7, l7, y7;
    logic obs_ready, obs_bit, obs_valid, obs_last, obs_busy;

    int checks = 0;
    int errors = 0;

    bit   data_q[$];
    bit   exp_q[$];
    logic got_q[$];

    always #5 clk = ~clk;

    conv_encoder_punct #(.K(3), .G0(3'b111), .G1(3'b101)) dut3 (
        .clk(clk), .rst(rst), .rate_sel_i(rate_sel), .in_bit_i(in_bit),
        .in_valid_i(in_valid & ~sel), .in_last_i(in_last), .in_ready_o(r3),
        .out_bit_o(b3), .out_valid_o(v3), .out_ready_i(out_ready & ~sel),
        .out_last_o(l3), .busy_o(y3)
    );

    conv_encoder_punct dut7 (
        .clk(clk), .rst(rst), .rate_sel_i(rate_sel), .in_bit_i(in_bit),
        .in_valid_i(in_valid & sel), .in_last_i(in_last), .in_ready_o(r7),
        .out_bit_o(b7), .out_valid_o(v7), .out_ready_i(out_ready & sel),
        .out_last_o(l7), .busy_o(y7)
    );

    assign obs_ready = sel ? r7 : r3;
    assign obs_bit   = sel ? b7 : b3;
    assign obs_valid = sel ? v7 : v3;
    assign obs_last  = sel ? l7 : l3;
    assign obs_busy  = sel ? y7 : y3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: encode data plus K-1 zeros, then keep bits by puncture phase.
    task automatic ref_encode(input int k, input int g0, input int g1, input int rate);
        int r, s, p, n, v, a, b;
        exp_q.delete();
        r = (rate == 3) ? 0 : rate;
        s = 0;
        p = 0;
        n = data_q.size() + k - 1;
        for (int i = 0; i < n; i++) begin
            v = (i < data_q.size()) ? int'(data_q[i]) : 0;
            a = $countones(((v << (k - 1)) | s) & g0) % 2;
            b = $countones(((v << (k - 1)) | s) & g1) % 2;
            if (r == 0 || p == 0) begin
                exp_q.push_back(1'(a));
                exp_q.push_back(1'(b));
            end else if (p == 1) begin
                exp_q.push_back(1'(a));
            end else begin
                exp_q.push_back(1'(b));
            end
            p = (p + 1) % (r + 1);
            s = (s >> 1) | (v << (k - 2));
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_bit%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // Sends data_q as one frame and collects the coded stream in got_q.
    // mode 0: out_ready=1, 1: pattern 1,0,0, 2: random. abort_after>=0 resets mid-frame.
    task automatic run_frame(input int rate, input int mode, input int abort_after);
        int   idx = 0, cyc = 0, acc_cyc = -1, bubbles = 0, pend = 0, r;
        bit   done = 0, prev_stall = 0, seen_valid = 0, exp_ready;
        logic prev_bit = 0, prev_last = 0;
        r = (rate == 3) ? 0 : rate;
        got_q.delete();
        while (!done && cyc < 4000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom);
            endcase
            if (idx < data_q.size()) begin
                in_valid = 1'b1;
                in_bit   = data_q[idx];
                in_last  = (idx == data_q.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                in_last  = 1'($urandom);
            end
            rate_sel = (idx == 0) ? 2'(rate) : 2'($urandom);
            #1;
            if (prev_stall) begin
                chk("stall_valid", 32'(obs_valid), 1);
                chk("stall_bit", 32'(obs_bit), 32'(prev_bit));
                chk("stall_last", 32'(obs_last), 32'(prev_last));
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                chk("first_latency", 32'(obs_valid), 1);
                chk("busy_rise", 32'(obs_busy), 1);
            end
            if (idx < data_q.size()) begin
                exp_ready = (pend == 0) || (pend == 1 && out_ready);
                chk("in_ready", 32'(obs_ready), 32'(exp_ready));
            end
            if (mode == 0 && seen_valid && !obs_valid) bubbles++;
            if (obs_valid) seen_valid = 1;
            if (obs_valid && out_ready) begin
                got_q.push_back(obs_bit);
                pend--;
                if (obs_last) done = 1;
            end
            if (in_valid && obs_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                pend += (r == 0 || idx % (r + 1) == 0) ? 2 : 1;
                idx++;
            end
            prev_stall = obs_valid && !out_ready;
            prev_bit   = obs_bit;
            prev_last  = obs_last;
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && got_q.size() >= abort_after) begin
                rst = 1'b1;
                in_valid = 1'b0;
                #1;
                chk("rst_valid", 32'(obs_valid), 0);
                chk("rst_bit", 32'(obs_bit), 0);
                chk("rst_last", 32'(obs_last), 0);
                chk("rst_busy", 32'(obs_busy), 0);
                chk("rst_ready", 32'(obs_ready), 0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("ready_after_rst", 32'(obs_ready), 1);
                return;
            end
        end
        chk("frame_done", 32'(done), 1);
        in_valid = 1'b0;
        #1;
        chk("busy_fall", 32'(obs_busy), 0);
        chk("idle_valid", 32'(obs_valid), 0);
        chk("idle_ready", 32'(obs_ready), 1);
        if (mode == 0) chk("no_bubbles", 32'(bubbles), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; sel = 1'b0; rate_sel = 2'd0;
        in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_valid", 32'(obs_valid), 0);
        chk("reset_bit", 32'(obs_bit), 0);
        chk("reset_last", 32'(obs_last), 0);
        chk("reset_busy", 32'(obs_busy), 0);
        chk("reset_ready", 32'(obs_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_reset", 32'(obs_ready), 1);
        @(negedge clk);

        data_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_q  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_frame(0, 0, -1);
        check_stream("r12");

        exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_frame(1, 0, -1);
        check_stream("r23");

        exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_frame(2, 0, -1);
        check_stream("r34");

        exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_frame(0, 1, -1);
        check_stream("r12_bp");

        run_frame(0, 2, -1);
        check_stream("b2b_f1");
        data_q = '{1'b1};
        exp_q  = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_frame(2, 2, -1);
        check_stream("b2b_f2");

        data_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_q  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_frame(0, 0, 3);
        run_frame(0, 0, -1);
        check_stream("after_abort");

        sel = 1'b1;
        foreach (data_q[i]) data_q[i] = 1'b0;
        for (int f = 0; f < 4; f++) begin
            int rate, mode, expected_len;
            case (f)
                0: begin n = 256; rate = 2; mode = 2; end
                1: begin n = 40;  rate = 0; mode = 2; end
                2: begin n = 37;  rate = 1; mode = 0; end
                default: begin n = 20; rate = 3; mode = 1; end
            endcase
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(1'($urandom));
            ref_encode(7, 'o171, 'o133, rate);
            run_frame(rate, mode, -1);
            check_stream($sformatf("k7_f%0d", f));
            case (rate)
                1:       expected_len = (3 * (n + 6) + 1) / 2;
                2:       expected_len = (4 * (n + 6) + 2) / 3;
                default: expected_len = 2 * (n + 6);
            endcase
            chk($sformatf("k7_f%0d_formula_len", f), 32'(got_q.size()), 32'(expected_len));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
# conv_encoder_punct

Parametrised, frame-based convolutional encoder for the transmit side of the Viterbi link, ahead of the channel/error-injection stage and the Viterbi decoder. It generalises the fixed rate-1/2 encoder with configurable constraint length and generator polynomials, and adds per-frame selectable puncturing (rates 1/2, 2/3, 3/4). It also adds automatic zero-tail termination and valid/ready handshakes on a serial coded-bit output.

## Interface
- K, 7, constraint length (3..9); state register is K-1 bits
- G0, 7'o171, generator for coded bit A; bit K-1 taps current input, bit 0 taps oldest state bit
- G1, 7'o133, generator for coded bit B, same tap ordering
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rate_sel_i  in  2  0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = treated as 1/2; sampled on the first accepted bit of a frame
- in_bit_i  in  1  data bit
- in_valid_i  in  1  data bit present
- in_last_i  in  1  marks the final data bit of the frame
- in_ready_o  out  1  encoder accepts in_bit_i this cycle
- out_bit_o  out  1  coded bit
- out_valid_o  out  1  out_bit_o valid
- out_ready_i  in  1  downstream accepts out_bit_o
- out_last_o  out  1  final coded bit of the frame (including tail)
- busy_o  out  1  frame in progress

## Operation
- Window w = {input, s}; s[K-2] is the most recent previous bit. A = ^(w & G0), B = ^(w & G1). After each encoded bit, s shifts in the input.
- Puncture phase p counts encoded bits (data and tail) mod period and resets to 0 at frame start.
  - Rate 1/2: period 1, emit A,B.
  - Rate 2/3: period 2. p=0 emits A,B; p=1 emits A.
  - Rate 3/4: period 3. p=0 emits A,B; p=1 emits A; p=2 emits B.
- Emission order within one encoded bit is always A then B. Each encoded bit loads a 2-entry holding register with a pending count of 1 or 2.
- FSM states:
  - IDLE: s = 0, p = 0, in_ready_o = 1. An accepted bit latches the rate, encodes, and moves to DATA, or to TAIL if in_last_i = 1.
  - DATA: accepts bits. Accepting a bit with in_last_i = 1 moves to TAIL with tail counter = K-1.
  - TAIL: in_ready_o = 0. Encodes K-1 zero inputs through the same puncture sequence, one per holding-register load. The last coded bit of the final tail load carries out_last_o = 1. When that bit completes its handshake, the FSM returns to IDLE.
- in_ready_o = (IDLE or DATA) and (pending == 0 or (pending == 1 and out_ready_i)). It depends combinationally on out_ready_i.
- Changes on rate_sel_i mid-frame are ignored.
- After the tail, s is all-zero, so back-to-back frames need no explicit clear. s is also forced to 0 on entry to IDLE.

## Timing
- Reset values: out_valid_o = 0, out_bit_o = 0, out_last_o = 0, busy_o = 0, in_ready_o = 0 while rst is high. State IDLE, s = 0, p = 0, pending = 0.
- in_ready_o = 1 in the first cycle after reset deasserts.
- Latency: a bit accepted at edge t drives its first coded bit on out_bit_o/out_valid_o after edge t. All outputs except in_ready_o are registered.
- With out_ready_i held at 1, one coded bit transfers per cycle with no bubbles. The input is stalled only while 2 coded bits are pending.
- Backpressure: while out_valid_o = 1 and out_ready_i = 0, out_bit_o and out_last_o hold stable.
- busy_o rises on the edge that accepts the first bit of a frame. It falls on the edge of the out_last_o handshake.
- Frame length: for N data bits, coded length is 2(N+K-1) at rate 1/2. Other rates follow the puncture pattern.
- Single-bit frame: a bit accepted with in_last_i = 1 in IDLE goes straight to TAIL.
- Reset mid-frame: immediate return to reset values. Partial output is discarded and the next frame starts at p = 0.

## Test plan
- Parameters K=3, G0=3'b111, G1=3'b101. Rate 1/2, input 1,0,1,1 (last on the 4th bit), out_ready_i = 1 -> coded stream 1,1,1,0,0,0,0,1,0,1,1,1 (12 bits), out_last_o on the 12th, busy_o falls after it.
- Same input at rate_sel_i = 1 -> 1,1,1,0,0,0,0,1,1 (9 bits). At rate_sel_i = 2 -> 1,1,1,0,0,1,0,1 (8 bits).
- Same rate-1/2 frame with out_ready_i toggling 1,0,0,1,... -> identical 12-bit stream. out_bit_o is stable across every stall, and in_ready_o = 0 whenever 2 bits are pending.
- Back-to-back frames: frame 2 (input 1, last) at rate 3/4, started in the cycle after frame 1's out_last handshake -> 1,1,1,1 with p restarting at 0. rate_sel_i changed mid-frame-1 has no effect on frame 1.
- Assert rst for 1 cycle after 3 coded bits of the rate-1/2 frame -> all outputs 0 immediately. Re-sending the frame reproduces the full 12-bit stream.
- Default K=7 (171/133), 256 random bits at rate 3/4, with rates 1/2 and 2/3 also covered -> output matches a reference model bit-exact. Coded lengths are 2(N+6), ceil(3(N+6)/2) and ceil(4(N+6)/3) for rates 1/2, 2/3 and 3/4 respectively.
